// File: rtl/dtlb.sv
// Fully-associative data TLB with 4 KB pages.
// IDLE -> LOOKUP -> IDLE on a hit or bypass, or -> MISS on a miss.
// MISS is released by miss_ack or flush.
// Entries are installed by fill. A fill first overwrites a matching valid VPN,
// otherwise it takes the lowest free slot, otherwise the round-robin victim.
module dtlb #(
  parameter int unsigned ENTRIES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lookup_valid,
  input  logic [31:0] vaddr,
  input  logic        translate_en,
  output logic        busy,
  output logic        dtlb_ready,
  output logic        dtlb_miss,
  output logic [31:0] paddr,
  input  logic        fill_valid,
  input  logic [19:0] fill_vpn,
  input  logic [19:0] fill_ppn,
  input  logic        flush,
  input  logic        miss_ack
);

  localparam int unsigned PTR_W = $clog2(ENTRIES);
  localparam int unsigned PN_W  = 20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS
  } state_e;

  state_e             state_q;
  logic               busy_q;
  logic               ready_q;
  logic               miss_q;
  logic [31:0]        paddr_q;
  logic [31:0]        vaddr_q;
  logic               xlate_q;

  logic [ENTRIES-1:0] valid_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PN_W-1:0]    vpn_q [ENTRIES];
  logic [PN_W-1:0]    ppn_q [ENTRIES];

  logic               lk_hit;
  logic [PN_W-1:0]    lk_ppn;
  logic               fill_match;
  logic [PTR_W-1:0]   match_idx;
  logic               has_free;
  logic [PTR_W-1:0]   free_idx;
  logic [PTR_W-1:0]   wr_idx;
  logic               ptr_adv;

  assign busy       = busy_q;
  assign dtlb_ready = ready_q;
  assign dtlb_miss  = miss_q;
  assign paddr      = paddr_q;

  // Single-cycle associative compare of the latched VPN against all valid entries.
  always_comb begin
    lk_hit = 1'b0;
    lk_ppn = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (valid_q[PTR_W'(i)] && (vpn_q[PTR_W'(i)] == vaddr_q[31:12])) begin
        lk_hit = 1'b1;
        lk_ppn = ppn_q[PTR_W'(i)];
      end
    end
  end

  // Fill slot selection: matching VPN first, then the lowest free slot, then the round-robin victim.
  always_comb begin
    fill_match = 1'b0;
    match_idx  = '0;
    has_free   = 1'b0;
    free_idx   = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (valid_q[PTR_W'(i)] && (vpn_q[PTR_W'(i)] == fill_vpn)) begin
        fill_match = 1'b1;
        match_idx  = PTR_W'(i);
      end
      if (!valid_q[PTR_W'(i)]) begin
        has_free = 1'b1;
        free_idx = PTR_W'(i);
      end
    end
    ptr_adv = !fill_match && !has_free;
    if (fill_match) begin
      wr_idx = match_idx;
    end else if (has_free) begin
      wr_idx = free_idx;
    end else begin
      wr_idx = ptr_q;
    end
  end

  // Valid bits and replacement pointer. A flush wins over a fill in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (flush) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (fill_valid) begin
      valid_q[wr_idx] <= 1'b1;
      if (ptr_adv) begin
        ptr_q <= (ptr_q == PTR_W'(ENTRIES - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
    end
  end

  // Translation storage. It has no reset because valid_q gates every read.
  always_ff @(posedge clock) begin
    if (fill_valid && !flush) begin
      vpn_q[wr_idx] <= fill_vpn;
      ppn_q[wr_idx] <= fill_ppn;
    end
  end

  // Request FSM with registered busy, ready, miss and paddr outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      miss_q  <= 1'b0;
      paddr_q <= '0;
      vaddr_q <= '0;
      xlate_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (lookup_valid) begin
            vaddr_q <= vaddr;
            xlate_q <= translate_en;
            state_q <= S_LOOKUP;
            busy_q  <= 1'b1;
          end
        end
        S_LOOKUP: begin
          ready_q <= 1'b1;
          if (!xlate_q || lk_hit) begin
            miss_q  <= 1'b0;
            paddr_q <= xlate_q ? {lk_ppn, vaddr_q[11:0]} : vaddr_q;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            miss_q  <= 1'b1;
            paddr_q <= vaddr_q;
            // A flush in the compare cycle still returns to IDLE on a miss.
            if (flush) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_MISS;
              busy_q  <= 1'b1;
            end
          end
        end
        S_MISS: begin
          if (miss_ack || flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
